laser_shot: RTL and testbench
=============================

Name: laser_shot

Overview:
- Downstream neighbour of the spaceship stage: consumes `gunPosition` and launches the player's single laser from the ship's nose.
- Moves the laser upward once per frame and retires it on an alien hit or when it leaves the top of the screen.
- Emits a per-pixel `color` code (LASER or NONE) for the pixel mux, plus the laser coordinates for the alien collision block.

Parameters:
- SCREEN_WIDTH, 640, visible pixels per line
- SCREEN_HEIGHT, 480, visible lines
- SHIP_HEIGHT, 30, ship sprite height in lines
- V_OFFSET, 10, top/bottom playfield margin in lines
- LASER_WIDTH, 4, laser width in pixels (even)
- LASER_HEIGHT, 12, laser height in lines
- LASER_SPEED, 8, lines moved up per frame
- COOLDOWN_FRAMES, 4, frames after a hit before the next launch is allowed
- LASER, 6, color code driven on laser pixels
- NONE, 7, color code driven on all other pixels

Ports:
- clk  in  1  pixel clock; hPos/vPos advance once per clk
- reset  in  1  asynchronous, active-high
- fire  in  1  fire button, synchronous, level
- gunPosition  in  10  ship centre x from the spaceship stage
- hPos  in  10  current pixel column
- vPos  in  10  current pixel line
- hit  in  1  one-cycle pulse from the collision block: laser struck an alien
- laserActive  out  1  laser in flight
- laserX  out  10  laser centre x
- laserY  out  10  laser top y
- color  out  3  LASER or NONE for the current pixel

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; laserActive=0; laserX=SCREEN_WIDTH/2; laserY=0; color=NONE.
  - fire history, pending-fire flag, hit flag and cooldown counter all cleared.
  - Reset mid-flight aborts the laser immediately.
- Frame strobe: internal one-cycle pulse when hPos==0 && vPos==SCREEN_HEIGHT. All motion and state changes other than flag capture occur on the strobe.
- Fire capture:
  - Rising edge of fire (registered fire_d) sets pending=1, but only while state==IDLE.
  - Edges seen in FLYING or COOLDOWN are discarded; there is no queueing.
  - pending is cleared at launch.
- Hit capture: hit sets hitFlag while FLYING; hitFlag is sticky until the next strobe consumes it. hit outside FLYING is ignored.
- FSM, evaluated on strobe:
  - IDLE: if pending, go to FLYING; latch laserX=gunPosition; laserY=SCREEN_HEIGHT-V_OFFSET-SHIP_HEIGHT-LASER_HEIGHT (428 with defaults); laserActive=1.
  - FLYING, checked in this priority order:
    - if hitFlag: go to COOLDOWN, laserActive=0, counter=COOLDOWN_FRAMES-1, clear hitFlag.
    - else if laserY < LASER_SPEED+V_OFFSET: go to IDLE, laserActive=0.
    - else laserY -= LASER_SPEED.
  - COOLDOWN: if counter==0, go to IDLE; else counter-1.
- Hit and strobe in the same cycle: the hit counts for that strobe (FLYING → COOLDOWN).
- laserX is frozen during flight; later gunPosition changes do not affect it.
- Pixel colour, registered with 1-cycle latency from hPos/vPos:
  - color=LASER when laserActive and laserX-LASER_WIDTH/2 <= hPos < laserX+LASER_WIDTH/2 and laserY <= vPos < laserY+LASER_HEIGHT.
  - Otherwise color=NONE.
  - Compare in 11-bit unsigned arithmetic with offsets added to the hPos/vPos side so nothing underflows (gunPosition near 0 is legal).
- laserX, laserY and laserActive are registered and change only on strobe or reset.

Optional Feature:
- Macro LASER_AUTOFIRE_EN.
- Defined: while fire is held high in IDLE, pending is set every cycle (level-triggered), so a held button relaunches on the first strobe after IDLE is reached.
- Undefined: launch only on a rising edge of fire captured in IDLE.

Test Plan:
- Reset, gunPosition=320, fire pulse in IDLE → first strobe: laserActive=1, laserX=320, laserY=428; next strobe laserY=420.
- Launch with no hit → laserY steps by 8 down to 12 after 52 move strobes; following strobe laserActive=0, state IDLE.
- hit pulse while laserY=300 → next strobe laserActive=0; fire pulses during the next 4 strobes are ignored; fire after COOLDOWN exits relaunches.
- Laser at laserX=320, laserY=428 → color==LASER exactly for hPos 318..321, vPos 428..439, one clk after the pixel; NONE elsewhere, including at hPos 317 and 322.
- Second fire pulse mid-flight → no effect on laserY sequence and no relaunch after exit until a new pulse; reset asserted mid-flight → laserActive=0 and color=NONE immediately.
- gunPosition=2 launch → laser pixels at hPos 0..3 only, no wrap to column 639 or above; hit coincident with strobe → COOLDOWN entered on that strobe.

Source files
------------

// File: rtl/laser_shot.sv
// -----------------------------------------------------------------------------
// laser_shot
//
// Purpose:
//   Launches the player's single laser from the ship's nose, moves it up by
//   LASER_SPEED lines once per frame, and retires it on an alien hit or when
//   it reaches the top playfield margin. After a hit the launcher is locked
//   out for COOLDOWN_FRAMES frames. A registered per-pixel colour code
//   (LASER / NONE) is produced for the pixel mux.
//
// Optional build macro:
//   LASER_AUTOFIRE_EN - when defined, a fire button held high in IDLE
//                       re-arms the launcher every cycle (level-triggered).
//                       When undefined, only a rising edge of fire seen in
//                       IDLE arms it.
//
// Ports:
//   clk          pixel clock; hPos/vPos advance once per clk
//   reset        asynchronous, active-high
//   fire         fire button, synchronous level
//   gunPosition  ship centre x (latched at launch)
//   hPos, vPos   current pixel column / line
//   hit          one-cycle pulse: laser struck an alien
//   laserActive  laser in flight
//   laserX       laser centre x
//   laserY       laser top y
//   color        LASER or NONE for the pixel presented one clk earlier
// -----------------------------------------------------------------------------
module laser_shot #(
   parameter int SCREEN_WIDTH    = 640,
   parameter int SCREEN_HEIGHT   = 480,
   parameter int SHIP_HEIGHT     = 30,
   parameter int V_OFFSET        = 10,
   parameter int LASER_WIDTH     = 4,
   parameter int LASER_HEIGHT    = 12,
   parameter int LASER_SPEED     = 8,
   parameter int COOLDOWN_FRAMES = 4,
   parameter int LASER           = 6,
   parameter int NONE            = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fire,
   input  logic [9:0] gunPosition,
   input  logic [9:0] hPos,
   input  logic [9:0] vPos,
   input  logic       hit,
   output logic       laserActive,
   output logic [9:0] laserX,
   output logic [9:0] laserY,
   output logic [2:0] color
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   // The counter only ever holds COOLDOWN_FRAMES-1 down to 0.
   localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

   localparam logic [9:0]       LAUNCH_Y = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - LASER_HEIGHT);
   localparam logic [9:0]       EXIT_Y   = 10'(LASER_SPEED + V_OFFSET);
   localparam logic [9:0]       SPEED    = 10'(LASER_SPEED);
   localparam logic [9:0]       CENTRE_X = 10'(SCREEN_WIDTH / 2);
   localparam logic [9:0]       STROBE_V = 10'(SCREEN_HEIGHT);
   localparam logic [10:0]      HALF_W   = 11'(LASER_WIDTH / 2);
   localparam logic [10:0]      FULL_W   = 11'(LASER_WIDTH);
   localparam logic [10:0]      FULL_H   = 11'(LASER_HEIGHT);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COOLDOWN_FRAMES - 1);
   localparam logic [2:0]       C_LASER  = 3'(LASER);
   localparam logic [2:0]       C_NONE   = 3'(NONE);

   state_t           state_q, state_d;
   logic             fire_q, fire_d;
   logic             pending_q, pending_d;
   logic             hit_flag_q, hit_flag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;
   logic [9:0]       laser_x_q, laser_x_d;
   logic [9:0]       laser_y_q, laser_y_d;
   logic [2:0]       color_q, color_d;

   logic             strobe;
   logic             fire_evt;
   logic             hit_now;
   logic [10:0]      h_ofs, x_ext, v_ext, y_ext;
   logic             in_x, in_y;

   always_comb begin
      strobe = (hPos == 10'd0) && (vPos == STROBE_V);

`ifdef LASER_AUTOFIRE_EN
      fire_evt = fire;
`else
      fire_evt = fire && !fire_q;
`endif

      state_d    = state_q;
      fire_d     = fire;
      pending_d  = pending_q;
      hit_flag_d = hit_flag_q;
      cnt_d      = cnt_q;
      active_d   = active_q;
      laser_x_d  = laser_x_q;
      laser_y_d  = laser_y_q;

      // Flag capture between strobes; edges outside IDLE are dropped.
      if (state_q == IDLE && fire_evt) begin
         pending_d = 1'b1;
      end
      if (state_q == FLYING && hit) begin
         hit_flag_d = 1'b1;
      end

      // A hit arriving on the strobe cycle itself still counts for this frame.
      hit_now = hit_flag_q || (hit && state_q == FLYING);

      if (strobe) begin
         hit_flag_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (pending_q) begin
                  state_d   = FLYING;
                  pending_d = 1'b0;
                  active_d  = 1'b1;
                  laser_x_d = gunPosition;
                  laser_y_d = LAUNCH_Y;
               end
            end
            FLYING: begin
               if (hit_now) begin
                  state_d  = COOLDOWN;
                  active_d = 1'b0;
                  cnt_d    = CNT_INIT;
               end else if (laser_y_q < EXIT_Y) begin
                  state_d  = IDLE;
                  active_d = 1'b0;
               end else begin
                  laser_y_d = laser_y_q - SPEED;
               end
            end
            COOLDOWN: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d  = IDLE;
               active_d = 1'b0;
            end
         endcase
      end

      // Offsets go on the pixel side so a laser near column 0 never wraps.
      h_ofs = {1'b0, hPos} + HALF_W;
      x_ext = {1'b0, laser_x_q};
      v_ext = {1'b0, vPos};
      y_ext = {1'b0, laser_y_q};
      in_x  = (h_ofs >= x_ext) && (h_ofs < x_ext + FULL_W);
      in_y  = (v_ext >= y_ext) && (v_ext < y_ext + FULL_H);

      color_d = (active_q && in_x && in_y) ? C_LASER : C_NONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         fire_q     <= 1'b0;
         pending_q  <= 1'b0;
         hit_flag_q <= 1'b0;
         cnt_q      <= '0;
         active_q   <= 1'b0;
         laser_x_q  <= CENTRE_X;
         laser_y_q  <= 10'd0;
         color_q    <= C_NONE;
      end else begin
         state_q    <= state_d;
         fire_q     <= fire_d;
         pending_q  <= pending_d;
         hit_flag_q <= hit_flag_d;
         cnt_q      <= cnt_d;
         active_q   <= active_d;
         laser_x_q  <= laser_x_d;
         laser_y_q  <= laser_y_d;
         color_q    <= color_d;
      end
   end

   assign laserActive = active_q;
   assign laserX      = laser_x_q;
   assign laserY      = laser_y_q;
   assign color       = color_q;

endmodule

// File: tb/tb_laser_shot.sv
// -----------------------------------------------------------------------------
// tb_laser_shot
//
// Directed testbench for laser_shot. The raster is not scanned; hPos/vPos
// are driven directly, and a frame strobe is produced by presenting
// hPos=0 / vPos=480 for one clock. Inputs change and outputs are sampled
// 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_laser_shot;

   logic       clk = 1'b0;
   logic       reset;
   logic       fire;
   logic [9:0] gunPosition;
   logic [9:0] hPos;
   logic [9:0] vPos;
   logic       hit;
   logic       laserActive;
   logic [9:0] laserX;
   logic [9:0] laserY;
   logic [2:0] color;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int C_LASER = 6;
   localparam int C_NONE  = 7;

   laser_shot dut (
      .clk         (clk),
      .reset       (reset),
      .fire        (fire),
      .gunPosition (gunPosition),
      .hPos        (hPos),
      .vPos        (vPos),
      .hit         (hit),
      .laserActive (laserActive),
      .laserX      (laserX),
      .laserY      (laserY),
      .color       (color)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame strobe; the raster then parks on a pixel far from the laser.
   task automatic strobe();
      hPos = 10'd0;
      vPos = 10'd480;
      tick();
      hPos = 10'd5;
      vPos = 10'd0;
      $display("strobe: active=%0d x=%0d y=%0d", laserActive, laserX, laserY);
   endtask

   task automatic pulse_fire();
      fire = 1'b1;
      tick();
      fire = 1'b0;
      tick();
   endtask

   task automatic pulse_hit();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      tick();
   endtask

   // Present one pixel, wait one clk, compare the registered colour.
   task automatic probe(input int h, input int v, input int exp);
      hPos = 10'(h);
      vPos = 10'(v);
      tick();
      $display("pixel h=%0d v=%0d color=%0d", h, v, color);
      check($sformatf("color(%0d,%0d)", h, v), int'(color), exp);
      hPos = 10'd5;
      vPos = 10'd0;
   endtask

   initial begin
      reset       = 1'b1;
      fire        = 1'b0;
      gunPosition = 10'd320;
      hPos        = 10'd5;
      vPos        = 10'd0;
      hit         = 1'b0;

      // Reset state
      #3;
      check("rst_active", int'(laserActive), 0);
      check("rst_x", int'(laserX), 320);
      check("rst_y", int'(laserY), 0);
      check("rst_color", int'(color), C_NONE);
      tick();
      reset = 1'b0;
      tick();

      // Launch from gunPosition=320
      pulse_fire();
      strobe();
      check("launch_active", int'(laserActive), 1);
      check("launch_x", int'(laserX), 320);
      check("launch_y", int'(laserY), 428);

      // Pixel window at x=320, y=428: columns 318..321, lines 428..439
      probe(318, 428, C_LASER);
      probe(321, 439, C_LASER);
      probe(319, 433, C_LASER);
      probe(317, 428, C_NONE);
      probe(322, 428, C_NONE);
      probe(320, 427, C_NONE);
      probe(320, 440, C_NONE);

      // laserX frozen during flight
      gunPosition = 10'd100;
      strobe();
      check("move1_y", int'(laserY), 420);
      check("frozen_x", int'(laserX), 320);

      // Second fire pulse mid-flight must have no effect
      pulse_fire();
      for (int k = 2; k <= 52; k++) begin
         strobe();
         check($sformatf("move%0d_y", k), int'(laserY), 428 - 8 * k);
         check($sformatf("move%0d_active", k), int'(laserActive), 1);
      end
      strobe();
      check("exit_active", int'(laserActive), 0);
      strobe();
      strobe();
      check("no_relaunch", int'(laserActive), 0);

      // Hit at laserY=300, with the hit flag held for a few cycles
      gunPosition = 10'd200;
      pulse_fire();
      strobe();
      check("l2_x", int'(laserX), 200);
      check("l2_y", int'(laserY), 428);
      for (int k = 0; k < 16; k++) strobe();
      check("l2_y300", int'(laserY), 300);
      pulse_hit();
      tick();
      strobe();
      check("hit_retire", int'(laserActive), 0);

      // Cooldown: fire pulses during the next four strobes are ignored
      for (int k = 1; k <= 4; k++) begin
         pulse_fire();
         strobe();
         check($sformatf("cool%0d_active", k), int'(laserActive), 0);
      end
      strobe();
      check("cool_no_queue", int'(laserActive), 0);

      // Hit while IDLE is ignored; relaunch after cooldown
      pulse_hit();
      gunPosition = 10'd400;
      pulse_fire();
      strobe();
      check("l3_active", int'(laserActive), 1);
      check("l3_x", int'(laserX), 400);
      strobe();
      check("l3_idle_hit_ignored", int'(laserActive), 1);
      check("l3_y", int'(laserY), 420);

      // Hit coincident with strobe retires on that strobe
      hit  = 1'b1;
      hPos = 10'd0;
      vPos = 10'd480;
      tick();
      hit  = 1'b0;
      hPos = 10'd5;
      vPos = 10'd0;
      check("coinc_hit", int'(laserActive), 0);
      check("coinc_y", int'(laserY), 420);
      pulse_fire();
      for (int k = 0; k < 4; k++) strobe();
      check("coinc_cooldown", int'(laserActive), 0);

      // Launch near the left edge: pixels 0..3 only, no wrap
      gunPosition = 10'd2;
      pulse_fire();
      strobe();
      check("l4_x", int'(laserX), 2);
      probe(0, 428, C_LASER);
      probe(3, 439, C_LASER);
      probe(4, 428, C_NONE);
      probe(639, 428, C_NONE);
      probe(1023, 428, C_NONE);
      probe(1022, 430, C_NONE);

      // Reset mid-flight takes effect immediately
      hPos = 10'd1;
      vPos = 10'd430;
      tick();
      check("pre_rst_color", int'(color), C_LASER);
      reset = 1'b1;
      #2;
      check("mid_rst_active", int'(laserActive), 0);
      check("mid_rst_color", int'(color), C_NONE);
      check("mid_rst_x", int'(laserX), 320);
      check("mid_rst_y", int'(laserY), 0);
      tick();
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
